// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles the signals exchanged between the pipeline (IRbuffers, execute
// stage, data-memory handshake) and the hazard/stall controller.
//
// Signals
//   IRbuffer1_out  32  instruction in the execute stage
//   IRbuffer2_out  32  instruction in the memory/writeback stage
//   br_taken_i      1  execute resolved a taken branch/jump this cycle
//   dmem_ready_i    1  data memory completes the IRbuffer2 access this cycle
//   stall_pc_o      1  hold PC
//   stall_ir1_o     1  hold IRbuffer1
//   stall_ir2_o     1  hold IRbuffer2 (memory wait)
//   bubble_ir2_o    1  load NOP into IRbuffer2 next edge
//   flush_ir1_o     1  load NOP into IRbuffer1 next edge
//
// Modports
//   master : pipeline side, drives instructions/status, receives controls
//   slave  : hazard controller side
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;
  logic [31:0] IRbuffer1_out;
  logic [31:0] IRbuffer2_out;
  logic        br_taken_i;
  logic        dmem_ready_i;
  logic        stall_pc_o;
  logic        stall_ir1_o;
  logic        stall_ir2_o;
  logic        bubble_ir2_o;
  logic        flush_ir1_o;

  modport master (
    output IRbuffer1_out, IRbuffer2_out, br_taken_i, dmem_ready_i,
    input  stall_pc_o, stall_ir1_o, stall_ir2_o, bubble_ir2_o, flush_ir1_o
  );

  modport slave (
    input  IRbuffer1_out, IRbuffer2_out, br_taken_i, dmem_ready_i,
    output stall_pc_o, stall_ir1_o, stall_ir2_o, bubble_ir2_o, flush_ir1_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Stall/flush controller for the 3-stage pipeline. Resolves the hazards that
// operand bypassing cannot: load-use (stall + bubble), data-memory wait
// (freeze everything upstream of memory) and taken redirects (flush IRbuffer1).
//
// Parameters
//   LOAD_STALL  load-use stall cycles (1..15)
//   FLUSH_CYC   cycles flush_ir1_o is held after a taken redirect (1..3)
//   CNT_W       width of the stall-cycle performance counter
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; forces all outputs to 0
//   hz           hazard_ctrl_if.slave (instructions, handshake, controls)
//   stall_cnt_o  saturating count of cycles with stall_pc_o = 1
//                (only when HAZARD_PERF_EN is defined)
//
// Optional feature macro: HAZARD_PERF_EN (adds stall_cnt_o and its counter).
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned FLUSH_CYC  = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_ctrl_if.slave     hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o
`endif
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [3:0] LOAD_RELOAD  = 4'(LOAD_STALL - 1);
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYC - 1);

  // Out-of-range parameters are rejected at elaboration.
  if (LOAD_STALL < 1 || LOAD_STALL > 15) begin : g_bad_load_stall
    $error("hazard_ctrl: LOAD_STALL must be 1..15");
  end
  if (FLUSH_CYC < 1 || FLUSH_CYC > 3) begin : g_bad_flush_cyc
    $error("hazard_ctrl: FLUSH_CYC must be 1..3");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_ctrl: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {RUN, LDSTALL, FLUSH} state_t;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;

  // ---------------------------------------------------------------------------
  // Decode. Register fields of instruction formats that do not read that
  // register are forced to x0, and x0 can never match a load destination
  // (rd = 0 is excluded), so unused fields cannot create a false hazard.
  // ---------------------------------------------------------------------------
  logic [6:0] ir1_op, ir2_op;
  logic [4:0] ir1_rs1, ir1_rs2, ir2_rd;
  logic       uses_rs1, uses_rs2;
  logic       ir2_is_load, ir2_is_mem;
  logic       load_use, mem_wait;

  assign ir1_op = hz.IRbuffer1_out[6:0];
  assign ir2_op = hz.IRbuffer2_out[6:0];
  assign ir2_rd = hz.IRbuffer2_out[11:7];

  assign uses_rs1 = (ir1_op == OP_R) || (ir1_op == OP_I) || (ir1_op == OP_LOAD) ||
                    (ir1_op == OP_STORE) || (ir1_op == OP_B) || (ir1_op == OP_JALR);
  assign uses_rs2 = (ir1_op == OP_R) || (ir1_op == OP_STORE) || (ir1_op == OP_B);

  assign ir1_rs1 = uses_rs1 ? hz.IRbuffer1_out[19:15] : 5'd0;
  assign ir1_rs2 = uses_rs2 ? hz.IRbuffer1_out[24:20] : 5'd0;

  assign ir2_is_load = (ir2_op == OP_LOAD);
  assign ir2_is_mem  = ir2_is_load || (ir2_op == OP_STORE);

  assign load_use = ir2_is_load && (ir2_rd != 5'd0) &&
                    ((ir2_rd == ir1_rs1) || (ir2_rd == ir1_rs2));
  assign mem_wait = ir2_is_mem && !hz.dmem_ready_i;

  // Instruction bits that play no part in hazard detection.
  logic unused_bits;
  assign unused_bits = ^{hz.IRbuffer1_out[31:25], hz.IRbuffer1_out[14:7],
                         hz.IRbuffer2_out[31:12]};

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and (Mealy) outputs. Memory wait outranks everything and
  // freezes state/cnt; a taken branch seen during any stall is simply
  // dropped because the branch re-resolves once IRbuffer1 is released.
  // Outputs are gated by rst_n so they drop as soon as reset is asserted.
  // ---------------------------------------------------------------------------
  logic stall_pc, stall_ir1, stall_ir2, bubble_ir2, flush_ir1;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_pc   = 1'b0;
    stall_ir1  = 1'b0;
    stall_ir2  = 1'b0;
    bubble_ir2 = 1'b0;
    flush_ir1  = 1'b0;

    if (!rst_n) begin
      state_next = RUN;
      cnt_next   = 4'd0;
    end else if (mem_wait) begin
      stall_pc  = 1'b1;
      stall_ir1 = 1'b1;
      stall_ir2 = 1'b1;
    end else begin
      case (state_reg)
        RUN: begin
          if (load_use) begin
            stall_pc   = 1'b1;
            stall_ir1  = 1'b1;
            bubble_ir2 = 1'b1;
            if (LOAD_STALL > 1) begin
              state_next = LDSTALL;
              cnt_next   = LOAD_RELOAD;
            end
          end else if (hz.br_taken_i) begin
            flush_ir1 = 1'b1;
            if (FLUSH_CYC > 1) begin
              state_next = FLUSH;
              cnt_next   = FLUSH_RELOAD;
            end
          end
        end
        LDSTALL: begin
          stall_pc   = 1'b1;
          stall_ir1  = 1'b1;
          bubble_ir2 = 1'b1;
          cnt_next   = cnt_reg - 4'd1;
          if (cnt_reg <= 4'd1) begin
            state_next = RUN;
            cnt_next   = 4'd0;
          end
        end
        FLUSH: begin
          flush_ir1 = 1'b1;
          cnt_next  = cnt_reg - 4'd1;
          if (cnt_reg <= 4'd1) begin
            state_next = RUN;
            cnt_next   = 4'd0;
          end
        end
        default: begin
          state_next = RUN;
          cnt_next   = 4'd0;
        end
      endcase
    end
  end

  assign hz.stall_pc_o   = stall_pc;
  assign hz.stall_ir1_o  = stall_ir1;
  assign hz.stall_ir2_o  = stall_ir2;
  assign hz.bubble_ir2_o = bubble_ir2;
  assign hz.flush_ir1_o  = flush_ir1;

`ifdef HAZARD_PERF_EN
  // Saturating count of PC-hold cycles.
  logic [CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (stall_pc && !(&stall_cnt_reg)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule
